// File: rtl/avalon_mem_bridge_pkg.sv
// Shared defaults for the Avalon-MM bridge and its traffic monitor.
//   - default bus widths used by the bridge top
//   - counter / outstanding widths and their types
//   - saturating increment helper for the 32-bit traffic counters
package avalon_mem_bridge_pkg;

   localparam int DEF_ADDR_WIDTH      = 27;
   localparam int DEF_DATA_WIDTH      = 512;
   localparam int DEF_BURST_CNT_WIDTH = 7;
   localparam int DEF_NUM_BANKS       = 2;
   localparam int CNT_WIDTH           = 32;
   localparam int OUTSTANDING_WIDTH   = 16;

   typedef logic [CNT_WIDTH-1:0]         cnt_t;
   typedef logic [OUTSTANDING_WIDTH-1:0] outstanding_t;

   function automatic cnt_t sat_inc(input cnt_t value, input logic en);
      return (en && (value != '1)) ? value + cnt_t'(1) : value;
   endfunction

endpackage

// File: rtl/avalon_mem_traffic_monitor.sv
// Traffic statistics and protocol checking for the Avalon-MM bridge.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   rd_accept, wr_accept         AFU command accepted (read / write beat)
//   cmd_err                      accepted command was malformed
//   rd_burstcount                burstcount of the accepted read
//   rsp_valid                    FIU read data beat returned
//   rd_req_cnt, wr_beat_cnt,
//   rd_resp_cnt                  saturating 32-bit traffic counters
//   outstanding                  read beats requested, not yet returned (saturating)
//   proto_err                    sticky protocol-error flag
module avalon_mem_traffic_monitor
   import avalon_mem_bridge_pkg::*;
#(
   parameter int BURST_CNT_WIDTH = DEF_BURST_CNT_WIDTH
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       rd_accept,
   input  logic                       wr_accept,
   input  logic                       cmd_err,
   input  logic [BURST_CNT_WIDTH-1:0] rd_burstcount,
   input  logic                       rsp_valid,
   output cnt_t                       rd_req_cnt,
   output cnt_t                       wr_beat_cnt,
   output cnt_t                       rd_resp_cnt,
   output outstanding_t               outstanding,
   output logic                       proto_err
);

   // One spare bit so the add can exceed 0xFFFF before clamping.
   localparam int SUM_W = ((BURST_CNT_WIDTH > OUTSTANDING_WIDTH) ?
                           BURST_CNT_WIDTH : OUTSTANDING_WIDTH) + 1;

   logic [SUM_W-1:0] out_sum;
   outstanding_t     out_next;
   logic             orphan_rsp;

   // A beat arriving with nothing outstanding is flagged and not subtracted,
   // so the count never wraps below zero.
   always_comb begin
      orphan_rsp = rsp_valid && (outstanding == '0);
      out_sum    = SUM_W'(outstanding);
      if (rd_accept) begin
         out_sum = out_sum + SUM_W'(rd_burstcount);
      end
      if (rsp_valid && !orphan_rsp) begin
         out_sum = out_sum - SUM_W'(1);
      end
      out_next = (out_sum > SUM_W'({OUTSTANDING_WIDTH{1'b1}})) ?
                 '1 : out_sum[OUTSTANDING_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_req_cnt  <= '0;
         wr_beat_cnt <= '0;
         rd_resp_cnt <= '0;
         outstanding <= '0;
         proto_err   <= 1'b0;
      end else begin
         rd_req_cnt  <= sat_inc(rd_req_cnt, rd_accept);
         wr_beat_cnt <= sat_inc(wr_beat_cnt, wr_accept);
         rd_resp_cnt <= sat_inc(rd_resp_cnt, rsp_valid);
         outstanding <= out_next;
         if (cmd_err || orphan_rsp) begin
            proto_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/avalon_mem_modport_bridge.sv
// Avalon-MM pass-through bridge between an AFU master and the FIU.
// One-entry registered request stage, one-cycle registered read response,
// plus a traffic monitor for counters / outstanding beats / protocol errors.
// Ports:
//   clk, reset_n                          clock, async active-low reset
//   afu_*  (address..byteenable in)       AFU command
//   afu_waitrequest, afu_readdata,
//   afu_readdatavalid (out)               AFU response / backpressure
//   fiu_*  (address..byteenable out)      FIU command from the stage
//   fiu_waitrequest, fiu_readdata,
//   fiu_readdatavalid (in)                FIU backpressure / response
//   bank_number                           constant BANK_ID
//   rd_req_cnt, wr_beat_cnt, rd_resp_cnt,
//   outstanding, proto_err                traffic monitor outputs
module avalon_mem_modport_bridge
   import avalon_mem_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int BURST_CNT_WIDTH = DEF_BURST_CNT_WIDTH,
   parameter int NUM_BANKS       = DEF_NUM_BANKS,
   parameter int BANK_ID         = 0,
   localparam int DATA_N_BYTES   = (DATA_WIDTH + 7) / 8,
   localparam int BANK_W         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                       clk,
   input  logic                       reset_n,

   input  logic [ADDR_WIDTH-1:0]      afu_address,
   input  logic                       afu_read,
   input  logic                       afu_write,
   input  logic [BURST_CNT_WIDTH-1:0] afu_burstcount,
   input  logic [DATA_WIDTH-1:0]      afu_writedata,
   input  logic [DATA_N_BYTES-1:0]    afu_byteenable,
   output logic                       afu_waitrequest,
   output logic [DATA_WIDTH-1:0]      afu_readdata,
   output logic                       afu_readdatavalid,

   output logic [ADDR_WIDTH-1:0]      fiu_address,
   output logic                       fiu_read,
   output logic                       fiu_write,
   output logic [BURST_CNT_WIDTH-1:0] fiu_burstcount,
   output logic [DATA_WIDTH-1:0]      fiu_writedata,
   output logic [DATA_N_BYTES-1:0]    fiu_byteenable,
   input  logic                       fiu_waitrequest,
   input  logic [DATA_WIDTH-1:0]      fiu_readdata,
   input  logic                       fiu_readdatavalid,

   output logic [BANK_W-1:0]          bank_number,
   output cnt_t                       rd_req_cnt,
   output cnt_t                       wr_beat_cnt,
   output cnt_t                       rd_resp_cnt,
   output outstanding_t               outstanding,
   output logic                       proto_err
);

   logic                       stage_valid;
   logic                       stage_read;
   logic                       stage_write;
   logic [ADDR_WIDTH-1:0]      stage_address;
   logic [BURST_CNT_WIDTH-1:0] stage_burstcount;
   logic [DATA_WIDTH-1:0]      stage_writedata;
   logic [DATA_N_BYTES-1:0]    stage_byteenable;

   logic accept;
   logic rd_accept;
   logic wr_accept;
   logic cmd_err;

   // The stage can take a new command whenever it is empty or draining this
   // cycle, so backpressure only reaches the AFU when the FIU stalls a full stage.
   assign afu_waitrequest = stage_valid && fiu_waitrequest;
   assign accept          = (afu_read || afu_write) && !afu_waitrequest;
   assign rd_accept       = accept && afu_read;
   assign wr_accept       = accept && afu_write;
   assign cmd_err         = accept && ((afu_read && afu_write) || (afu_burstcount == '0));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage_valid      <= 1'b0;
         stage_read       <= 1'b0;
         stage_write      <= 1'b0;
         stage_address    <= '0;
         stage_burstcount <= '0;
         stage_writedata  <= '0;
         stage_byteenable <= '0;
      end else if (accept) begin
         stage_valid      <= 1'b1;
         stage_read       <= afu_read;
         stage_write      <= afu_write;
         stage_address    <= afu_address;
         stage_burstcount <= afu_burstcount;
         stage_writedata  <= afu_writedata;
         stage_byteenable <= afu_byteenable;
      end else if (!fiu_waitrequest) begin
         stage_valid      <= 1'b0;
      end
   end

   assign fiu_read       = stage_valid && stage_read;
   assign fiu_write      = stage_valid && stage_write;
   assign fiu_address    = stage_address;
   assign fiu_burstcount = stage_burstcount;
   assign fiu_writedata  = stage_writedata;
   assign fiu_byteenable = stage_byteenable;

   // Read data holds its last value between beats.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         afu_readdatavalid <= 1'b0;
         afu_readdata      <= '0;
      end else begin
         afu_readdatavalid <= fiu_readdatavalid;
         if (fiu_readdatavalid) begin
            afu_readdata <= fiu_readdata;
         end
      end
   end

   assign bank_number = BANK_W'(BANK_ID);

   avalon_mem_traffic_monitor #(
      .BURST_CNT_WIDTH (BURST_CNT_WIDTH)
   ) u_monitor (
      .clk           (clk),
      .reset_n       (reset_n),
      .rd_accept     (rd_accept),
      .wr_accept     (wr_accept),
      .cmd_err       (cmd_err),
      .rd_burstcount (afu_burstcount),
      .rsp_valid     (fiu_readdatavalid),
      .rd_req_cnt    (rd_req_cnt),
      .wr_beat_cnt   (wr_beat_cnt),
      .rd_resp_cnt   (rd_resp_cnt),
      .outstanding   (outstanding),
      .proto_err     (proto_err)
   );

endmodule

// File: tb/tb_avalon_mem_modport_bridge.sv
module tb_avalon_mem_modport_bridge;

   localparam int AW  = 27;
   localparam int DW  = 512;
   localparam int BW  = 7;
   localparam int NB  = (DW + 7) / 8;

   logic          clk;
   logic          reset_n;
   logic [AW-1:0] afu_address;
   logic          afu_read;
   logic          afu_write;
   logic [BW-1:0] afu_burstcount;
   logic [DW-1:0] afu_writedata;
   logic [NB-1:0] afu_byteenable;
   logic          afu_waitrequest;
   logic [DW-1:0] afu_readdata;
   logic          afu_readdatavalid;
   logic [AW-1:0] fiu_address;
   logic          fiu_read;
   logic          fiu_write;
   logic [BW-1:0] fiu_burstcount;
   logic [DW-1:0] fiu_writedata;
   logic [NB-1:0] fiu_byteenable;
   logic          fiu_waitrequest;
   logic [DW-1:0] fiu_readdata;
   logic          fiu_readdatavalid;
   logic [0:0]    bank_number;
   logic [31:0]   rd_req_cnt;
   logic [31:0]   wr_beat_cnt;
   logic [31:0]   rd_resp_cnt;
   logic [15:0]   outstanding;
   logic          proto_err;

   int total = 0;
   int bad   = 0;
   int pops  = 0;
   logic [63:0] exp_q[$];

   avalon_mem_modport_bridge #(
      .ADDR_WIDTH      (AW),
      .DATA_WIDTH      (DW),
      .BURST_CNT_WIDTH (BW),
      .NUM_BANKS       (2),
      .BANK_ID         (1)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .afu_address       (afu_address),
      .afu_read          (afu_read),
      .afu_write         (afu_write),
      .afu_burstcount    (afu_burstcount),
      .afu_writedata     (afu_writedata),
      .afu_byteenable    (afu_byteenable),
      .afu_waitrequest   (afu_waitrequest),
      .afu_readdata      (afu_readdata),
      .afu_readdatavalid (afu_readdatavalid),
      .fiu_address       (fiu_address),
      .fiu_read          (fiu_read),
      .fiu_write         (fiu_write),
      .fiu_burstcount    (fiu_burstcount),
      .fiu_writedata     (fiu_writedata),
      .fiu_byteenable    (fiu_byteenable),
      .fiu_waitrequest   (fiu_waitrequest),
      .fiu_readdata      (fiu_readdata),
      .fiu_readdatavalid (fiu_readdatavalid),
      .bank_number       (bank_number),
      .rd_req_cnt        (rd_req_cnt),
      .wr_beat_cnt       (wr_beat_cnt),
      .rd_resp_cnt       (rd_resp_cnt),
      .outstanding       (outstanding),
      .proto_err         (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      afu_address       = '0;
      afu_read          = 1'b0;
      afu_write         = 1'b0;
      afu_burstcount    = '0;
      afu_writedata     = '0;
      afu_byteenable    = '0;
      fiu_waitrequest   = 1'b0;
      fiu_readdata      = '0;
      fiu_readdatavalid = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      step();
      step();
      exp_q.delete();
      reset_n = 1'b1;
   endtask

   // Scoreboard: every read beat leaving the bridge must match the oldest beat fed in.
   always @(negedge clk) begin
      if (reset_n && afu_readdatavalid) begin
         pops++;
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 64'd1, 64'd0);
         end else begin
            chk("rsp_data", afu_readdata[63:0], exp_q.pop_front());
         end
      end
   end

   initial begin
      idle_inputs();
      reset_n = 1'b0;
      #12;
      chk("rst_fiu_read",   {63'b0, fiu_read}, 64'd0);
      chk("rst_fiu_write",  {63'b0, fiu_write}, 64'd0);
      chk("rst_rdvalid",    {63'b0, afu_readdatavalid}, 64'd0);
      chk("rst_rd_req_cnt", {32'b0, rd_req_cnt}, 64'd0);
      chk("rst_outstanding",{48'b0, outstanding}, 64'd0);
      chk("rst_proto_err",  {63'b0, proto_err}, 64'd0);
      chk("rst_bank",       {63'b0, bank_number}, 64'd1);

      // Read burst presented the same cycle reset releases: first edge accepts it.
      step();
      reset_n        = 1'b1;
      afu_read       = 1'b1;
      afu_address    = 27'h100;
      afu_burstcount = 7'd4;
      #1;
      chk("rd_waitreq", {63'b0, afu_waitrequest}, 64'd0);
      step();
      afu_read = 1'b0;
      chk("rd_fiu_read",  {63'b0, fiu_read}, 64'd1);
      chk("rd_fiu_addr",  {37'b0, fiu_address}, 64'h100);
      chk("rd_fiu_burst", {57'b0, fiu_burstcount}, 64'd4);
      chk("rd_req_cnt",   {32'b0, rd_req_cnt}, 64'd1);
      chk("rd_outst",     {48'b0, outstanding}, 64'd4);
      step();
      chk("rd_drained",   {63'b0, fiu_read}, 64'd0);

      // Four response beats, each visible to the AFU one cycle later.
      for (int i = 0; i < 4; i++) begin
         fiu_readdatavalid = 1'b1;
         fiu_readdata      = DW'(64'hA + 64'(i));
         exp_q.push_back(64'hA + 64'(i));
         step();
         chk("rsp_latency", {63'b0, afu_readdatavalid}, 64'd1);
      end
      fiu_readdatavalid = 1'b0;
      fiu_readdata      = DW'(64'h55);
      step();
      step();
      chk("rsp_hold_data", afu_readdata[63:0], 64'hD);
      chk("rsp_cnt",       {32'b0, rd_resp_cnt}, 64'd4);
      chk("rsp_outst",     {48'b0, outstanding}, 64'd0);
      chk("rsp_proto_err", {63'b0, proto_err}, 64'd0);
      chk("rsp_pops",      64'(pops), 64'd4);

      // FIU stalls a full stage for three cycles; second write waits its turn.
      fiu_waitrequest = 1'b1;
      afu_write       = 1'b1;
      afu_address     = 27'h200;
      afu_burstcount  = 7'd1;
      afu_writedata   = DW'(64'h11);
      afu_byteenable  = '1;
      step();
      afu_address   = 27'h204;
      afu_writedata = DW'(64'h22);
      for (int i = 0; i < 3; i++) begin
         chk("stall_waitreq", {63'b0, afu_waitrequest}, 64'd1);
         chk("stall_addr",    {37'b0, fiu_address}, 64'h200);
         chk("stall_wdata",   fiu_writedata[63:0], 64'h11);
         chk("stall_fiu_wr",  {63'b0, fiu_write}, 64'd1);
         chk("stall_wr_cnt",  {32'b0, wr_beat_cnt}, 64'd1);
         step();
      end
      fiu_waitrequest = 1'b0;
      #1;
      chk("release_waitreq", {63'b0, afu_waitrequest}, 64'd0);
      step();
      afu_write = 1'b0;
      chk("second_wr_addr",  {37'b0, fiu_address}, 64'h204);
      chk("second_wr_data",  fiu_writedata[63:0], 64'h22);
      chk("second_wr_cnt",   {32'b0, wr_beat_cnt}, 64'd2);
      step();
      chk("wr_drained",      {63'b0, fiu_write}, 64'd0);
      chk("wr_cnt_final",    {32'b0, wr_beat_cnt}, 64'd2);

      // Orphan response with nothing outstanding.
      fiu_readdatavalid = 1'b1;
      fiu_readdata      = DW'(64'h77);
      exp_q.push_back(64'h77);
      step();
      fiu_readdatavalid = 1'b0;
      chk("orphan_err",   {63'b0, proto_err}, 64'd1);
      chk("orphan_outst", {48'b0, outstanding}, 64'd0);
      chk("orphan_cnt",   {32'b0, rd_resp_cnt}, 64'd5);
      step();
      step();
      chk("orphan_sticky", {63'b0, proto_err}, 64'd1);
      do_reset();
      chk("err_cleared",   {63'b0, proto_err}, 64'd0);

      // Read and write asserted together.
      afu_read       = 1'b1;
      afu_write      = 1'b1;
      afu_burstcount = 7'd1;
      step();
      idle_inputs();
      chk("rw_both_err", {63'b0, proto_err}, 64'd1);
      do_reset();

      // Zero burstcount read.
      afu_read       = 1'b1;
      afu_burstcount = 7'd0;
      step();
      idle_inputs();
      chk("bc0_err",     {63'b0, proto_err}, 64'd1);
      chk("bc0_req_cnt", {32'b0, rd_req_cnt}, 64'd1);
      chk("bc0_outst",   {48'b0, outstanding}, 64'd0);
      do_reset();

      // Reset mid-burst: staged command, outstanding beats and response in flight.
      afu_read       = 1'b1;
      afu_address    = 27'h300;
      afu_burstcount = 7'd8;
      step();
      fiu_waitrequest   = 1'b1;
      afu_address       = 27'h340;
      fiu_readdatavalid = 1'b1;
      fiu_readdata      = DW'(64'h99);
      exp_q.push_back(64'h99);
      step();
      chk("mid_rdvalid", {63'b0, afu_readdatavalid}, 64'd1);
      chk("mid_outst",   {48'b0, outstanding}, 64'd7);
      chk("mid_fiu_rd",  {63'b0, fiu_read}, 64'd1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_fiu_read", {63'b0, fiu_read}, 64'd0);
      chk("arst_rdvalid",  {63'b0, afu_readdatavalid}, 64'd0);
      chk("arst_rdata",    {63'b0, |afu_readdata}, 64'd0);
      chk("arst_fiu_addr", {37'b0, fiu_address}, 64'd0);
      chk("arst_rd_cnt",   {32'b0, rd_req_cnt}, 64'd0);
      chk("arst_rsp_cnt",  {32'b0, rd_resp_cnt}, 64'd0);
      chk("arst_outst",    {48'b0, outstanding}, 64'd0);
      chk("arst_waitreq",  {63'b0, afu_waitrequest}, 64'd0);
      chk("arst_bank",     {63'b0, bank_number}, 64'd1);
      exp_q.delete();
      idle_inputs();
      step();
      reset_n = 1'b1;
      step();
      chk("end_queue", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
